vcb_mod_updown_counter: RTL and testbench

Parametrised successor to the single-digit loadable up/down counter. It chains DIGITS modulo-MOD digits into one counter, for example BCD with MOD=10. Adds a saturate/wrap mode select and a sticky overflow flag with a clear input. It sits in timer, display and event-count datapaths. TC and CEO keep their cascade role so wider counters can still be chained.

---
 rtl/vcb_mod_updown_counter.sv | 88 ++++++++
 tb/tb_vcb_mod_updown_counter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vcb_mod_updown_counter.sv
// Multi-digit modulo-MOD up/down counter (BCD with MOD=10), with parallel load,
// saturate/wrap mode, sticky overflow flag and TC/CEO for cascading.
module vcb_mod_updown_counter #(
  parameter int DIGITS = 4,
  parameter int MOD    = 10
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       ce,
  input  logic                       up,
  input  logic                       L,
  input  logic [DIGITS*$clog2(MOD)-1:0] di,
  input  logic                       sat,
  input  logic                       ovf_clr,
  output logic [DIGITS*$clog2(MOD)-1:0] Q,
  output logic                       TC,
  output logic                       CEO,
  output logic                       OVF
);

  localparam int W  = $clog2(MOD);
  localparam int QW = DIGITS * W;
  localparam logic [W-1:0] DMAX = W'(MOD - 1);

  logic [QW-1:0] q_q, q_d;
  logic          ovf_q, ovf_d;
  logic          all_max, all_zero, tc, term_evt;
  logic [W-1:0]  dig;
  logic          step_en;

  // Terminal detection looks at the whole count; it feeds TC and the flag.
  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (q_q[k*W +: W] != DMAX) all_max  = 1'b0;
      if (q_q[k*W +: W] != '0)   all_zero = 1'b0;
    end
    tc       = up ? all_max : all_zero;
    term_evt = !L && ce && tc;
  end

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    q_d     = q_q;
    ovf_d   = ovf_q;
    dig     = '0;
    step_en = 1'b1;
    if (L) begin
      for (int k = 0; k < DIGITS; k++) begin
        dig = di[k*W +: W];
        q_d[k*W +: W] = (dig > DMAX) ? DMAX : dig;
      end
    end else if (ce && !(sat && tc)) begin
      // Ripple the step enable upward: a digit moves only when every lower
      // digit sits at its terminal value for the current direction.
      for (int k = 0; k < DIGITS; k++) begin
        dig = q_q[k*W +: W];
        if (step_en) begin
          if (up) q_d[k*W +: W] = (dig == DMAX) ? '0 : dig + 1'b1;
          else    q_d[k*W +: W] = (dig == '0)   ? DMAX : dig - 1'b1;
        end
        step_en = step_en && (up ? (dig == DMAX) : (dig == '0));
      end
    end
    if (ovf_clr)  ovf_d = 1'b0;
    if (term_evt) ovf_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign OVF = ovf_q;
  assign TC  = tc;
  assign CEO = ce & tc;

endmodule

// File: tb/tb_vcb_mod_updown_counter.sv
// Directed bench for vcb_mod_updown_counter (DIGITS=4, MOD=10): expected Q/OVF
// are queued when an edge is driven and checked after that edge.
module tb_vcb_mod_updown_counter;

  logic        clk = 1'b0;
  logic        clr, ce, up, L, sat, ovf_clr;
  logic [15:0] di;
  logic [15:0] Q;
  logic        TC, CEO, OVF;

  typedef struct {
    string       tag;
    logic [15:0] q;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  vcb_mod_updown_counter #(.DIGITS(4), .MOD(10)) dut (
    .clk(clk), .clr(clr), .ce(ce), .up(up), .L(L), .di(di), .sat(sat),
    .ovf_clr(ovf_clr), .Q(Q), .TC(TC), .CEO(CEO), .OVF(OVF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: treat the BCD word as a decimal integer.
  function automatic logic [15:0] bcd_add1(input logic [15:0] v);
    int n;
    n = v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
    n = (n + 1) % 10000;
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Queue the expectation, clock one edge, then pop and compare 1 time unit later.
  task automatic step(input string tag, input logic [15:0] eq, input logic eovf);
    exp_t e;
    sb.push_back('{tag, eq, eovf});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".Q"}, Q, e.q);
    check({e.tag, ".OVF"}, {15'd0, OVF}, {15'd0, e.ovf});
  endtask

  initial begin
    logic [15:0] m;
    clr = 1'b1; ce = 1'b0; up = 1'b0; L = 1'b0; sat = 1'b0; ovf_clr = 1'b0; di = '0;
    #12;
    check("rst.Q", Q, 16'h0000);
    check("rst.OVF", {15'd0, OVF}, 16'd0);
    check("rst.TC_down_zero", {15'd0, TC}, 16'd1);
    check("rst.CEO_ce0", {15'd0, CEO}, 16'd0);
    @(negedge clk); clr = 1'b0;

    // Down wrap from zero
    ce = 1'b1; up = 1'b0; #1;
    check("dwrap.TC_pre", {15'd0, TC}, 16'd1);
    check("dwrap.CEO_pre", {15'd0, CEO}, 16'd1);
    step("dwrap", 16'h9999, 1'b1);
    check("dwrap.TC_post", {15'd0, TC}, 16'd0);

    // Load zero (OVF untouched), then count up 37 against the decimal model
    L = 1'b1; di = 16'h0000;
    step("load0", 16'h0000, 1'b1);
    L = 1'b0; up = 1'b1; m = 16'h0000;
    for (int i = 0; i < 37; i++) begin
      m = bcd_add1(m);
      step("cnt", m, 1'b1);
    end
    check("cnt.final", Q, 16'h0037);

    // Async reset between edges, held across an edge, then resume
    #2; clr = 1'b1; #1;
    check("async.Q", Q, 16'h0000);
    check("async.OVF", {15'd0, OVF}, 16'd0);
    @(posedge clk); #1;
    check("async.hold_Q", Q, 16'h0000);
    #2; clr = 1'b0;
    step("resume", 16'h0001, 1'b0);

    // BCD carry and borrow across two digits; middle borrow
    L = 1'b1; di = 16'h0099;
    step("bcd.load", 16'h0099, 1'b0);
    L = 1'b0; up = 1'b1;
    step("bcd.carry", 16'h0100, 1'b0);
    up = 1'b0;
    step("bcd.borrow", 16'h0099, 1'b0);
    L = 1'b1; di = 16'h1000;
    step("mid.load", 16'h1000, 1'b0);
    L = 1'b0;
    step("mid.borrow", 16'h0999, 1'b0);

    // Saturate at 9999
    L = 1'b1; di = 16'h9999; up = 1'b1; sat = 1'b1;
    step("sat.load", 16'h9999, 1'b0);
    L = 1'b0;
    for (int i = 0; i < 3; i++) step("sat.hold", 16'h9999, 1'b1);
    check("sat.TC", {15'd0, TC}, 16'd1);
    ce = 1'b0; #1;
    check("sat.CEO_ce0", {15'd0, CEO}, 16'd0);
    check("sat.TC_ce0", {15'd0, TC}, 16'd1);
    up = 1'b0; #1;
    check("dir.TC_comb", {15'd0, TC}, 16'd0);
    up = 1'b1;

    // Hold with ce=0 while clearing OVF
    ovf_clr = 1'b1;
    step("ovfclr", 16'h9999, 1'b0);
    ovf_clr = 1'b0;
    step("hold", 16'h9999, 1'b0);

    // Load has priority over a terminal count and clamps digits
    sat = 1'b0; ce = 1'b1; L = 1'b1; di = 16'h00AF;
    step("clamp", 16'h0099, 1'b0);
    di = 16'hF5A3;
    step("clamp2", 16'h9593, 1'b0);

    // OVF set wins over a simultaneous clear; wrap up to zero
    di = 16'h9999;
    step("race.load", 16'h9999, 1'b0);
    L = 1'b0; up = 1'b1; ovf_clr = 1'b1;
    step("race.set", 16'h0000, 1'b1);
    ce = 1'b0;
    step("race.clr", 16'h0000, 1'b0);
    ovf_clr = 1'b0;

    // Saturate at zero counting down
    ce = 1'b1; up = 1'b0; sat = 1'b1;
    step("satdn", 16'h0000, 1'b1);

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got %0d leftover expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
